// File: rtl/tile_ram_write_scheduler.sv
// tile_ram_write_scheduler
//
// Drives the write port of the tile-map RAM that pixel_drawer reads. Two
// requesters share the port: A (game logic, board marks) and B
// (cursor/overlay highlight tiles). A built-in sequencer fills the whole
// screen with CLEAR_CODE. When GATE_WINDOW=1, writes happen only while
// window_i (vertical blank) is high, so the visible frame never tears.
//
// Ports:
//   clk_i         write-side clock
//   rst_i         asynchronous, active-high reset
//   window_i      write window (vertical blank from vga_sync)
//   clear_req_i   single-cycle pulse, start a clear
//   req_a_i       requester A write request (level, held until ack)
//   addr_a_i      requester A tile address
//   data_a_i      requester A tile code
//   ack_a_o       one-cycle acknowledge to A
//   req_b_i       requester B write request (level, held until ack)
//   addr_b_i      requester B tile address
//   data_b_i      requester B tile code
//   ack_b_o       one-cycle acknowledge to B
//   write_addr_o  RAM write address
//   data_o        RAM write data
//   we_o          RAM write enable
//   busy_o        clear in progress
//   clear_done_o  one-cycle pulse when a clear finishes
module tile_ram_write_scheduler #(
    parameter int unsigned RAM_DATA_WIDTH = 7,
    parameter int unsigned RAM_ADDR_WIDTH = 9,
    parameter int unsigned TILE_COUNT     = 300,
    parameter int unsigned CLEAR_CODE     = 0,
    parameter int unsigned GATE_WINDOW    = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      window_i,
    input  logic                      clear_req_i,
    input  logic                      req_a_i,
    input  logic [RAM_ADDR_WIDTH-1:0] addr_a_i,
    input  logic [RAM_DATA_WIDTH-1:0] data_a_i,
    output logic                      ack_a_o,
    input  logic                      req_b_i,
    input  logic [RAM_ADDR_WIDTH-1:0] addr_b_i,
    input  logic [RAM_DATA_WIDTH-1:0] data_b_i,
    output logic                      ack_b_o,
    output logic [RAM_ADDR_WIDTH-1:0] write_addr_o,
    output logic [RAM_DATA_WIDTH-1:0] data_o,
    output logic                      we_o,
    output logic                      busy_o,
    output logic                      clear_done_o
);

    localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR  = RAM_ADDR_WIDTH'(TILE_COUNT - 1);
    localparam logic [RAM_DATA_WIDTH-1:0] CLEAR_DATA = RAM_DATA_WIDTH'(CLEAR_CODE);

    typedef enum logic { IDLE, CLEAR } state_t;
    typedef enum logic { GRANT_A, GRANT_B } grant_t;

    state_t                    state_q, state_d;
    grant_t                    last_q, last_d;
    logic [RAM_ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                      fin_q, fin_d;

    logic                      we_d, ack_a_d, ack_b_d, busy_d, done_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_d;
    logic [RAM_DATA_WIDTH-1:0] data_d;

    logic win;
    logic elig_a, elig_b, pick_a;

    assign win = (GATE_WINDOW != 0) ? window_i : 1'b1;

    // A requester still showing its ack this cycle is about to drop or
    // change its request, so it must not be granted a second time.
    assign elig_a = req_a_i && !ack_a_o;
    assign elig_b = req_b_i && !ack_b_o;
    assign pick_a = elig_a && (!elig_b || (last_q == GRANT_B));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_q       <= GRANT_B;
            cnt_q        <= '0;
            fin_q        <= 1'b0;
            we_o         <= 1'b0;
            write_addr_o <= '0;
            data_o       <= '0;
            ack_a_o      <= 1'b0;
            ack_b_o      <= 1'b0;
            busy_o       <= 1'b0;
            clear_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            fin_q        <= fin_d;
            we_o         <= we_d;
            write_addr_o <= addr_d;
            data_o       <= data_d;
            ack_a_o      <= ack_a_d;
            ack_b_o      <= ack_b_d;
            busy_o       <= busy_d;
            clear_done_o <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        fin_d   = fin_q;
        we_d    = 1'b0;
        addr_d  = write_addr_o;
        data_d  = data_o;
        ack_a_d = 1'b0;
        ack_b_d = 1'b0;
        busy_d  = busy_o;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (clear_req_i) begin
                    state_d = CLEAR;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                    fin_d   = 1'b0;
                end else if (win && (elig_a || elig_b)) begin
                    we_d = 1'b1;
                    if (pick_a) begin
                        addr_d  = addr_a_i;
                        data_d  = data_a_i;
                        ack_a_d = 1'b1;
                        last_d  = GRANT_A;
                    end else begin
                        addr_d  = addr_b_i;
                        data_d  = data_b_i;
                        ack_b_d = 1'b1;
                        last_d  = GRANT_B;
                    end
                end
            end
            CLEAR: begin
                busy_d = 1'b1;
                // fin_q marks that the last tile was written on the previous
                // edge; busy stays high through that write and drops together
                // with the done pulse. This also avoids relying on the counter
                // reaching TILE_COUNT, which may not fit when it is 2^width.
                if (fin_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    fin_d   = 1'b0;
                end else if (win) begin
                    we_d   = 1'b1;
                    addr_d = cnt_q;
                    data_d = CLEAR_DATA;
                    cnt_d  = cnt_q + 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        fin_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_tile_ram_write_scheduler.sv
// Directed testbench for tile_ram_write_scheduler (default parameters).
module tb_tile_ram_write_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       window_i;
    logic       clear_req_i;
    logic       req_a_i;
    logic [8:0] addr_a_i;
    logic [6:0] data_a_i;
    logic       ack_a_o;
    logic       req_b_i;
    logic [8:0] addr_b_i;
    logic [6:0] data_b_i;
    logic       ack_b_o;
    logic [8:0] write_addr_o;
    logic [6:0] data_o;
    logic       we_o;
    logic       busy_o;
    logic       clear_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    tile_ram_write_scheduler #(
        .RAM_DATA_WIDTH(7),
        .RAM_ADDR_WIDTH(9),
        .TILE_COUNT    (300),
        .CLEAR_CODE    (0),
        .GATE_WINDOW   (1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .window_i    (window_i),
        .clear_req_i (clear_req_i),
        .req_a_i     (req_a_i),
        .addr_a_i    (addr_a_i),
        .data_a_i    (data_a_i),
        .ack_a_o     (ack_a_o),
        .req_b_i     (req_b_i),
        .addr_b_i    (addr_b_i),
        .data_b_i    (data_b_i),
        .ack_b_o     (ack_b_o),
        .write_addr_o(write_addr_o),
        .data_o      (data_o),
        .we_o        (we_o),
        .busy_o      (busy_o),
        .clear_done_o(clear_done_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        window_i = 1'b0; clear_req_i = 1'b0;
        req_a_i = 1'b0; addr_a_i = '0; data_a_i = '0;
        req_b_i = 1'b0; addr_b_i = '0; data_b_i = '0;
        tick();
        tick();
        n_cmp++; if (we_o !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", we_o); end
        n_cmp++; if (write_addr_o !== 9'd0) begin n_bad++; $display("FAIL reset_addr: got %0d want 0", write_addr_o); end
        n_cmp++; if (data_o !== 7'd0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", data_o); end
        n_cmp++; if ({ack_a_o, ack_b_o} !== 2'b00) begin n_bad++; $display("FAIL reset_acks: got %b want 00", {ack_a_o, ack_b_o}); end
        n_cmp++; if ({busy_o, clear_done_o} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_done: got %b want 00", {busy_o, clear_done_o}); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_a;
        int writes;
        window_i = 1'b1;
        req_a_i = 1'b1; addr_a_i = 9'd42; data_a_i = 7'd5;
        tick();
        n_cmp++; if (we_o !== 1'b1) begin n_bad++; $display("FAIL single_we: got %b want 1", we_o); end
        n_cmp++; if (write_addr_o !== 9'd42) begin n_bad++; $display("FAIL single_addr: got %0d want 42", write_addr_o); end
        n_cmp++; if (data_o !== 7'd5) begin n_bad++; $display("FAIL single_data: got %0d want 5", data_o); end
        n_cmp++; if ({ack_a_o, ack_b_o} !== 2'b10) begin n_bad++; $display("FAIL single_acks: got %b want 10", {ack_a_o, ack_b_o}); end
        req_a_i = 1'b0; addr_a_i = 9'd0; data_a_i = 7'd0;
        writes = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (we_o === 1'b1) writes++;
        end
        n_cmp++; if (writes !== 0) begin n_bad++; $display("FAIL single_extra_writes: got %0d want 0", writes); end
        n_cmp++; if ({write_addr_o, data_o} !== {9'd42, 7'd5}) begin n_bad++; $display("FAIL single_hold: got addr %0d data %0d want 42 5", write_addr_o, data_o); end
    endtask

    task automatic test_contention;
        logic exp_a;
        apply_reset();
        window_i = 1'b1;
        req_a_i = 1'b1; addr_a_i = 9'd1; data_a_i = 7'd11;
        req_b_i = 1'b1; addr_b_i = 9'd2; data_b_i = 7'd22;
        for (int i = 0; i < 4; i++) begin
            exp_a = (i % 2 == 0);
            tick();
            n_cmp++; if (we_o !== 1'b1) begin n_bad++; $display("FAIL contend_we[%0d]: got %b want 1", i, we_o); end
            n_cmp++; if (write_addr_o !== (exp_a ? 9'd1 : 9'd2)) begin n_bad++; $display("FAIL contend_addr[%0d]: got %0d want %0d", i, write_addr_o, exp_a ? 1 : 2); end
            n_cmp++; if (data_o !== (exp_a ? 7'd11 : 7'd22)) begin n_bad++; $display("FAIL contend_data[%0d]: got %0d want %0d", i, data_o, exp_a ? 11 : 22); end
            n_cmp++; if ({ack_a_o, ack_b_o} !== {exp_a, !exp_a}) begin n_bad++; $display("FAIL contend_acks[%0d]: got %b want %b", i, {ack_a_o, ack_b_o}, {exp_a, !exp_a}); end
        end
        req_a_i = 1'b0; req_b_i = 1'b0;
        tick();
        n_cmp++; if ({we_o, ack_a_o, ack_b_o} !== 3'b000) begin n_bad++; $display("FAIL contend_idle: got %b want 000", {we_o, ack_a_o, ack_b_o}); end
    endtask

    task automatic test_window_gating;
        int early;
        window_i = 1'b0;
        req_b_i = 1'b1; addr_b_i = 9'd77; data_b_i = 7'd3;
        early = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (we_o !== 1'b0 || ack_b_o !== 1'b0) early++;
        end
        n_cmp++; if (early !== 0) begin n_bad++; $display("FAIL gate_closed_writes: got %0d want 0", early); end
        window_i = 1'b1;
        tick();
        n_cmp++; if ({we_o, ack_b_o, ack_a_o} !== 3'b110) begin n_bad++; $display("FAIL gate_open_we_ack: got %b want 110", {we_o, ack_b_o, ack_a_o}); end
        n_cmp++; if ({write_addr_o, data_o} !== {9'd77, 7'd3}) begin n_bad++; $display("FAIL gate_open_addr_data: got %0d %0d want 77 3", write_addr_o, data_o); end
        req_b_i = 1'b0;
        tick();
        n_cmp++; if (we_o !== 1'b0) begin n_bad++; $display("FAIL gate_after: got %b want 0", we_o); end
    endtask

    task automatic test_clear_full;
        int bad, first_bad;
        window_i = 1'b1;
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        n_cmp++; if ({busy_o, we_o} !== 2'b10) begin n_bad++; $display("FAIL clear_start: busy,we got %b want 10", {busy_o, we_o}); end
        bad = 0; first_bad = -1;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (we_o !== 1'b1 || write_addr_o !== 9'(i) || data_o !== 7'd0 ||
                busy_o !== 1'b1 || clear_done_o !== 1'b0) begin
                bad++;
                if (first_bad < 0) first_bad = i;
            end
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL clear_sequence: got %0d bad cycles (first at %0d) want 0", bad, first_bad); end
        tick();
        n_cmp++; if ({busy_o, clear_done_o, we_o} !== 3'b010) begin n_bad++; $display("FAIL clear_end: busy,done,we got %b want 010", {busy_o, clear_done_o, we_o}); end
        tick();
        n_cmp++; if ({busy_o, clear_done_o, we_o} !== 3'b000) begin n_bad++; $display("FAIL clear_after: busy,done,we got %b want 000", {busy_o, clear_done_o, we_o}); end
    endtask

    task automatic test_clear_paused;
        int exp_addr, gate_bad, seq_bad, early_ack, dones;
        logic done_seen, ack_seen, win_at_edge;
        logic [8:0] ack_addr;
        logic [6:0] ack_data;
        window_i = 1'b1;
        req_a_i = 1'b1; addr_a_i = 9'd200; data_a_i = 7'd9;
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        n_cmp++; if ({busy_o, ack_a_o, we_o} !== 3'b100) begin n_bad++; $display("FAIL pause_start: busy,ack,we got %b want 100", {busy_o, ack_a_o, we_o}); end
        exp_addr = 0; gate_bad = 0; seq_bad = 0; early_ack = 0; dones = 0;
        done_seen = 1'b0; ack_seen = 1'b0; ack_addr = '0; ack_data = '0;
        for (int k = 0; k < 1200 && !ack_seen; k++) begin
            window_i = ((k / 100) % 2 == 0);
            win_at_edge = window_i;
            tick();
            if (clear_done_o === 1'b1) begin dones++; done_seen = 1'b1; end
            if (ack_a_o === 1'b1) begin
                if (!done_seen) early_ack++;
                ack_seen = 1'b1;
                ack_addr = write_addr_o;
                ack_data = data_o;
                req_a_i = 1'b0;
            end else if (we_o === 1'b1) begin
                if (!win_at_edge) gate_bad++;
                if (write_addr_o !== 9'(exp_addr) || data_o !== 7'd0) seq_bad++;
                exp_addr++;
            end
        end
        n_cmp++; if (exp_addr !== 300) begin n_bad++; $display("FAIL pause_write_count: got %0d want 300", exp_addr); end
        n_cmp++; if (gate_bad !== 0) begin n_bad++; $display("FAIL pause_gated: got %0d writes in closed window want 0", gate_bad); end
        n_cmp++; if (seq_bad !== 0) begin n_bad++; $display("FAIL pause_contiguous: got %0d bad writes want 0", seq_bad); end
        n_cmp++; if (dones !== 1) begin n_bad++; $display("FAIL pause_done_count: got %0d want 1", dones); end
        n_cmp++; if ({ack_seen, early_ack != 0} !== 2'b10) begin n_bad++; $display("FAIL pause_ack_order: seen,early got %b want 10", {ack_seen, early_ack != 0}); end
        n_cmp++; if ({ack_addr, ack_data} !== {9'd200, 7'd9}) begin n_bad++; $display("FAIL pause_ack_write: got %0d %0d want 200 9", ack_addr, ack_data); end
        req_a_i = 1'b0;
        window_i = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_clear;
        int budget, dones;
        window_i = 1'b1;
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        budget = 0;
        // Stop once write 149 is out: the internal counter then holds 150.
        while (!(we_o === 1'b1 && write_addr_o === 9'd149) && budget < 400) begin
            tick();
            budget++;
        end
        n_cmp++; if (budget >= 400) begin n_bad++; $display("FAIL midclr_reach150: got timeout want write 149"); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({we_o, busy_o, ack_a_o, ack_b_o, clear_done_o} !== 5'b00000) begin n_bad++; $display("FAIL midclr_async: we,busy,acka,ackb,done got %b want 00000", {we_o, busy_o, ack_a_o, ack_b_o, clear_done_o}); end
        tick();
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (clear_done_o !== 1'b0 || we_o !== 1'b0 || busy_o !== 1'b0) dones++;
        end
        n_cmp++; if (dones !== 0) begin n_bad++; $display("FAIL midclr_no_done: got %0d active cycles want 0", dones); end
        clear_req_i = 1'b1;
        tick();
        clear_req_i = 1'b0;
        tick();
        n_cmp++; if ({we_o, busy_o, write_addr_o} !== {2'b11, 9'd0}) begin n_bad++; $display("FAIL midclr_restart: we,busy,addr got %b %b %0d want 1 1 0", we_o, busy_o, write_addr_o); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_single_a();
        test_contention();
        test_window_gating();
        test_clear_full();
        test_clear_paused();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tile_ram_write_scheduler.md
Name: tile_ram_write_scheduler

Overview:
- Owns the write port of the tile-map RAM (simple_dual_port_ram_dual_clock) that pixel_drawer reads.
- Shares that port between two requesters: game logic (A, board marks) and cursor/overlay logic (B, highlight tiles).
- Provides a built-in clear-screen sequencer.
- Writes can be restricted to the vertical blanking window so the visible frame never tears.

Parameters:
- RAM_DATA_WIDTH, 7, tile code width
- RAM_ADDR_WIDTH, 9, tile address width
- TILE_COUNT, 300, tiles per screen (20x15 of 32x32 px)
- CLEAR_CODE, 0, tile code written by clear sequence
- GATE_WINDOW, 1, 1 = write only while window_i high; 0 = window_i ignored (treated as 1)

Ports:
- clk_i  in  1  write-side clock
- rst_i  in  1  asynchronous, active-high reset
- window_i  in  1  write window (vertical blank from vga_sync)
- clear_req_i  in  1  single-cycle pulse, start clear
- req_a_i  in  1  requester A write request (level)
- addr_a_i  in  RAM_ADDR_WIDTH  requester A tile address
- data_a_i  in  RAM_DATA_WIDTH  requester A tile code
- ack_a_o  out  1  one-cycle acknowledge to A
- req_b_i  in  1  requester B write request (level)
- addr_b_i  in  RAM_ADDR_WIDTH  requester B tile address
- data_b_i  in  RAM_DATA_WIDTH  requester B tile code
- ack_b_o  out  1  one-cycle acknowledge to B
- write_addr_o  out  RAM_ADDR_WIDTH  to RAM write_addr_i
- data_o  out  RAM_DATA_WIDTH  to RAM data_i
- we_o  out  1  to RAM we_i
- busy_o  out  1  clear in progress
- clear_done_o  out  1  one-cycle pulse, clear finished

Behaviour:
- All outputs registered; reset value 0 for every output. Internal state resets to IDLE, clear counter 0, last_grant = B.
- win = window_i when GATE_WINDOW=1, else 1.
- States: IDLE, CLEAR.
- IDLE:
  - clear_req_i=1 -> CLEAR next cycle. busy_o=1 from that cycle. Counter = 0. No grant issued in the same cycle.
  - Otherwise, if win=1 and at least one eligible request, grant one requester. Requester X is eligible when req_x_i=1 and ack_x_o=0 in that cycle, which prevents double-granting a request being dropped.
  - Next cycle after a grant: we_o=1, write_addr_o/data_o = the granted requester's addr/data as sampled at grant, and ack_x_o=1. Latency: request sampled at edge N, write and ack at edge N+1.
  - Round-robin: if both are eligible, grant the one not in last_grant, then update last_grant. A single eligible requester is always granted.
  - Requester rule: hold req/addr/data stable until ack is seen. Drop req or present a new address/data the cycle after ack.
- CLEAR:
  - Each cycle with win=1: we_o=1, write_addr_o=counter, data_o=CLEAR_CODE, counter+1.
  - win=0: we_o=0 and counter holds; the sequence pauses across active video.
  - After the write of address TILE_COUNT-1: return to IDLE, busy_o=0, clear_done_o=1 for exactly one cycle (same cycle as busy_o falls).
  - Requests are never acked in CLEAR; they stay pending and are served in IDLE.
  - clear_req_i during CLEAR is ignored; the counter is not restarted.
- Boundary rules:
  - At most one write per cycle; ack_a_o and ack_b_o are never high together.
  - we_o=0 in any cycle without a grant or clear write. write_addr_o and data_o hold their last values when we_o=0.
  - Window closing: if window_i falls in the grant cycle, the already-registered write still completes in the next cycle.
  - Requester address is passed through unchecked; addresses >= TILE_COUNT are legal.
  - Counter width is RAM_ADDR_WIDTH. TILE_COUNT <= 2^RAM_ADDR_WIDTH.
  - Asynchronous reset mid-clear: immediate return to IDLE, busy_o=0, no clear_done_o pulse, we_o=0.

Test Plan:
- Single A write: window_i=1, req_a_i=1, addr_a_i=9'd42, data_a_i=7'd5 for 1 cycle until ack -> next edge we_o=1, write_addr_o=42, data_o=5, ack_a_o=1; exactly one write.
- Contention: A and B both held (A addr 1, B addr 2) from reset, window_i=1 -> writes alternate: A(1) first, then B(2). Each ack lasts one cycle; no cycle has both acks.
- Window gating: GATE_WINDOW=1, req_b_i held with window_i=0 for 50 cycles -> we_o=0 throughout. Window rises -> write and ack_b_o one cycle later.
- Clear full: clear_req_i pulse with window_i=1 -> 300 consecutive we_o cycles, addresses 0..299, data 0. busy_o high for those 300 cycles; clear_done_o pulses once with busy_o falling.
- Clear paused with pending request: window_i toggles 100 on / 100 off during clear, req_a_i held -> addresses stay contiguous and no write occurs while the window is low. ack_a_o only after clear_done_o, write lands at A's address.
- Reset mid-clear: rst_i asserted at counter=150 -> we_o, busy_o, acks go 0 asynchronously. No clear_done_o. A new clear_req_i restarts from address 0.
